cmd_decode: RTL



---
 rtl/cmd_pkg.sv | 97 +++++++++
 rtl/ebv_tracker.sv | 42 ++++
 rtl/cmd_decode.sv | 109 ++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared command definitions: one-hot packet types, opcode literals, payload
// lengths and decoder state. The packet parser imports this package too.
package cmd_pkg;

    localparam int PT_W  = 12;
    localparam int CNT_W = 6;

    localparam logic [PT_W-1:0] PT_QUERYREP = 12'b0000_0000_0001;
    localparam logic [PT_W-1:0] PT_ACK      = 12'b0000_0000_0010;
    localparam logic [PT_W-1:0] PT_QUERY    = 12'b0000_0000_0100;
    localparam logic [PT_W-1:0] PT_QUERYADJ = 12'b0000_0000_1000;
    localparam logic [PT_W-1:0] PT_SELECT   = 12'b0000_0001_0000;
    localparam logic [PT_W-1:0] PT_NAK      = 12'b0000_0010_0000;
    localparam logic [PT_W-1:0] PT_REQRN    = 12'b0000_0100_0000;
    localparam logic [PT_W-1:0] PT_READ     = 12'b0000_1000_0000;
    localparam logic [PT_W-1:0] PT_WRITE    = 12'b0001_0000_0000;
    localparam logic [PT_W-1:0] PT_TRNS     = 12'b0010_0000_0000;
    localparam logic [PT_W-1:0] PT_SAMPSENS = 12'b0100_0000_0000;
    localparam logic [PT_W-1:0] PT_SENSDATA = 12'b1000_0000_0000;

    localparam logic [1:0] OPC_QUERYREP = 2'b00;
    localparam logic [1:0] OPC_ACK      = 2'b01;
    localparam logic [3:0] OPC_QUERY    = 4'b1000;
    localparam logic [3:0] OPC_QUERYADJ = 4'b1001;
    localparam logic [3:0] OPC_SELECT   = 4'b1010;
    localparam logic [3:0] OPC_BAD4     = 4'b1011;
    localparam logic [7:0] OPC_NAK      = 8'b1100_0000;
    localparam logic [7:0] OPC_REQRN    = 8'b1100_0001;
    localparam logic [7:0] OPC_READ     = 8'b1100_0010;
    localparam logic [7:0] OPC_WRITE    = 8'b1100_0011;
    localparam logic [7:0] OPC_TRNS     = 8'b1110_0000;
    localparam logic [7:0] OPC_SAMPSENS = 8'b1110_0001;
    localparam logic [7:0] OPC_SENSDATA = 8'b1110_0010;

    localparam logic [CNT_W-1:0] LEN_NONE       = 6'd0;
    localparam logic [CNT_W-1:0] LEN_QUERYREP   = 6'd2;
    localparam logic [CNT_W-1:0] LEN_ACK        = 6'd16;
    localparam logic [CNT_W-1:0] LEN_QUERY      = 6'd18;
    localparam logic [CNT_W-1:0] LEN_QUERYADJ   = 6'd5;
    localparam logic [CNT_W-1:0] LEN_REQRN      = 6'd32;
    localparam logic [CNT_W-1:0] LEN_TRNS       = 6'd6;
    localparam logic [CNT_W-1:0] LEN_SAMPSENS   = 6'd3;
    localparam logic [CNT_W-1:0] LEN_SENSDATA   = 6'd36;
    localparam logic [CNT_W-1:0] LEN_BANK       = 6'd2;
    localparam logic [CNT_W-1:0] LEN_READ_DATA  = 6'd40;
    localparam logic [CNT_W-1:0] LEN_WRITE_DATA = 6'd48;

    localparam logic [2:0] EBV_MAX_GROUPS = 3'd4;

    typedef enum logic [2:0] {OPC, PAYLOAD, EBV, DONE, BAD} state_t;

    typedef struct packed {
        logic             bad;
        logic [PT_W-1:0]  pt;
        logic [CNT_W-1:0] len;
    } decode_t;

    // code holds the bits received so far, right-aligned; nbits is how many.
    // An all-zero result with bad=0 means the opcode is not complete yet.
    function automatic decode_t decode_opcode(input logic [7:0] code, input logic [3:0] nbits);
        decode_t d;
        d = '0;
        case (nbits)
            4'd2: begin
                case (code[1:0])
                    OPC_QUERYREP: begin d.pt = PT_QUERYREP; d.len = LEN_QUERYREP; end
                    OPC_ACK:      begin d.pt = PT_ACK;      d.len = LEN_ACK;      end
                    default:      d = '0;
                endcase
            end
            4'd4: begin
                case (code[3:0])
                    OPC_QUERY:    begin d.pt = PT_QUERY;    d.len = LEN_QUERY;    end
                    OPC_QUERYADJ: begin d.pt = PT_QUERYADJ; d.len = LEN_QUERYADJ; end
                    OPC_SELECT:   begin d.pt = PT_SELECT;   d.len = LEN_NONE;     end
                    OPC_BAD4:     d.bad = 1'b1;
                    default:      d = '0;
                endcase
            end
            4'd8: begin
                case (code)
                    OPC_NAK:      begin d.pt = PT_NAK;      d.len = LEN_NONE;     end
                    OPC_REQRN:    begin d.pt = PT_REQRN;    d.len = LEN_REQRN;    end
                    OPC_READ:     begin d.pt = PT_READ;     d.len = LEN_BANK;     end
                    OPC_WRITE:    begin d.pt = PT_WRITE;    d.len = LEN_BANK;     end
                    OPC_TRNS:     begin d.pt = PT_TRNS;     d.len = LEN_TRNS;     end
                    OPC_SAMPSENS: begin d.pt = PT_SAMPSENS; d.len = LEN_SAMPSENS; end
                    OPC_SENSDATA: begin d.pt = PT_SENSDATA; d.len = LEN_SENSDATA; end
                    default:      d.bad = 1'b1;
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ebv_tracker.sv
// Walks the 8-bit groups of an EBV pointer; flags the last bit of the final
// group and a fifth group that still claims an extension.
module ebv_tracker
    import cmd_pkg::*;
(
    input  logic bitinclk,
    input  logic reset,
    input  logic enable,
    input  logic bitin,
    output logic ebv_done,
    output logic ebv_overflow
);

    logic [2:0] bit_pos;
    logic [2:0] group_cnt;
    logic       ext_flag;

    always_ff @(posedge bitinclk or posedge reset) begin
        if (reset) begin
            bit_pos   <= 3'd0;
            group_cnt <= 3'd0;
            ext_flag  <= 1'b0;
        end else if (!enable) begin
            bit_pos   <= 3'd0;
            group_cnt <= 3'd0;
            ext_flag  <= 1'b0;
        end else begin
            if (bit_pos == 3'd0) begin
                ext_flag <= bitin;
            end
            if (bit_pos == 3'd7) begin
                group_cnt <= group_cnt + 3'd1;
            end
            bit_pos <= bit_pos + 3'd1;
        end
    end

    // Both flags describe the bit being sampled now, so the parent acts on this edge.
    assign ebv_overflow = enable && (bit_pos == 3'd0) && (group_cnt == EBV_MAX_GROUPS) && bitin;
    assign ebv_done     = enable && (bit_pos == 3'd7) && !ext_flag;

endmodule

// File: rtl/cmd_decode.sv
// Command decoder: shifts in opcode bits, presents a one-hot packet type and
// tracks the payload length up to the last bit of the command.
module cmd_decode
    import cmd_pkg::*;
(
    input  logic            bitinclk,
    input  logic            reset,
    input  logic            bitin,
    output logic [PT_W-1:0] packettype,
    output logic            cmd_valid,
    output logic            cmd_invalid,
    output logic [3:0]      opcode_bits,
    output logic            packet_done
);

    state_t           state;
    logic [6:0]       opc_sr;
    logic [CNT_W-1:0] cnt;
    logic             bank_phase;
    logic             is_write;
    logic [7:0]       opc_next;
    logic [3:0]       opc_nbits;
    decode_t          dec;
    logic             ebv_active;
    logic             ebv_done;
    logic             ebv_overflow;

    // While in OPC the counter doubles as the count of opcode bits already taken.
    assign opc_next   = {opc_sr, bitin};
    assign opc_nbits  = {1'b0, cnt[2:0]} + 4'd1;
    assign dec        = decode_opcode(opc_next, opc_nbits);
    assign ebv_active = (state == EBV);

    ebv_tracker u_ebv (
        .bitinclk     (bitinclk),
        .reset        (reset),
        .enable       (ebv_active),
        .bitin        (bitin),
        .ebv_done     (ebv_done),
        .ebv_overflow (ebv_overflow)
    );

    always_ff @(posedge bitinclk or posedge reset) begin
        if (reset) begin
            state       <= OPC;
            opc_sr      <= '0;
            cnt         <= '0;
            bank_phase  <= 1'b0;
            is_write    <= 1'b0;
            packettype  <= '0;
            cmd_valid   <= 1'b0;
            cmd_invalid <= 1'b0;
            opcode_bits <= 4'd0;
            packet_done <= 1'b0;
        end else begin
            case (state)
                OPC: begin
                    opc_sr <= opc_next[6:0];
                    if (dec.bad) begin
                        cmd_invalid <= 1'b1;
                        opcode_bits <= opc_nbits;
                        state       <= BAD;
                    end else if (dec.pt != '0) begin
                        packettype  <= dec.pt;
                        cmd_valid   <= 1'b1;
                        opcode_bits <= opc_nbits;
                        cnt         <= dec.len;
                        is_write    <= (dec.pt == PT_WRITE);
                        bank_phase  <= (dec.pt == PT_READ) || (dec.pt == PT_WRITE);
                        if (dec.pt == PT_NAK) begin
                            packet_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // A zero count only happens for SELECT, which is never length-tracked.
                PAYLOAD: begin
                    if (cnt == CNT_W'(1)) begin
                        if (bank_phase) begin
                            bank_phase <= 1'b0;
                            cnt        <= '0;
                            state      <= EBV;
                        end else begin
                            packet_done <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                EBV: begin
                    if (ebv_overflow) begin
                        cmd_invalid <= 1'b1;
                        state       <= BAD;
                    end else if (ebv_done) begin
                        cnt   <= is_write ? LEN_WRITE_DATA : LEN_READ_DATA;
                        state <= PAYLOAD;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule
